// File: rtl/kbd_playback_ctrl.sv
// kbd_playback_ctrl: decodes keyboard ASCII strokes into music player controls
// (direction, pause, restart) and generates the adjustable sample-rate strobe.
module kbd_playback_ctrl #(
  parameter int unsigned DIV_DEFAULT = 2272,
  parameter int unsigned DIV_STEP    = 64,
  parameter int unsigned DIV_MIN     = 256,
  parameter int unsigned DIV_MAX     = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  key_ascii,
  input  logic        key_valid,
  output logic        kybrd_forward,
  output logic        kybrd_pause,
  output logic        kybrd_reset,
  output logic        startsamplenow,
  output logic [15:0] divisor
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = DW + 1;

  logic          fwd, fwd_nxt;
  logic          pause, pause_nxt;
  logic          rst_p, rst_p_nxt;
  logic          strobe, strobe_nxt;
  logic [DW-1:0] div, div_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] div_dec, div_inc;
  logic          cnt_last;

  logic key_e, key_d, key_f, key_b, key_r, key_plus, key_minus, key_zero;

  // Qualified key decode; letters accept either case
  always_comb begin
    key_e     = key_valid && (key_ascii == 8'h45 || key_ascii == 8'h65);
    key_d     = key_valid && (key_ascii == 8'h44 || key_ascii == 8'h64);
    key_f     = key_valid && (key_ascii == 8'h46 || key_ascii == 8'h66);
    key_b     = key_valid && (key_ascii == 8'h42 || key_ascii == 8'h62);
    key_r     = key_valid && (key_ascii == 8'h52 || key_ascii == 8'h72);
    key_plus  = key_valid && (key_ascii == 8'h2B);
    key_minus = key_valid && (key_ascii == 8'h2D);
    key_zero  = key_valid && (key_ascii == 8'h30);
  end

  // Saturating divisor step in 17 bits so neither direction can wrap
  always_comb begin
    div_dec = CW'(DIV_MIN);
    if ({1'b0, div} >= CW'(DIV_MIN + DIV_STEP)) begin
      div_dec = {1'b0, div} - CW'(DIV_STEP);
    end
    div_inc = {1'b0, div} + CW'(DIV_STEP);
    if (div_inc > CW'(DIV_MAX)) begin
      div_inc = CW'(DIV_MAX);
    end
  end

  // Terminal count; >= lets a shrunken divisor wrap on the next edge
  assign cnt_last = (cnt >= (div - DW'(1)));

  // Next-state for playback controls and the strobe generator
  always_comb begin
    fwd_nxt    = fwd;
    pause_nxt  = pause;
    div_nxt    = div;
    rst_p_nxt  = 1'b0;
    cnt_nxt    = cnt;
    strobe_nxt = 1'b0;

    if (key_e)     pause_nxt = 1'b0;
    if (key_d)     pause_nxt = 1'b1;
    if (key_f)     fwd_nxt   = 1'b1;
    if (key_b)     fwd_nxt   = 1'b0;
    if (key_r)     rst_p_nxt = 1'b1;
    if (key_plus)  div_nxt   = DW'(div_dec);
    if (key_minus) div_nxt   = DW'(div_inc);
    if (key_zero)  div_nxt   = DW'(DIV_DEFAULT);

    // Restart wins over the strobe; pause is the value before this edge
    if (key_r) begin
      cnt_nxt    = '0;
      strobe_nxt = 1'b0;
    end else if (pause) begin
      cnt_nxt    = '0;
      strobe_nxt = 1'b0;
    end else if (cnt_last) begin
      cnt_nxt    = '0;
      strobe_nxt = 1'b1;
    end else begin
      cnt_nxt    = cnt + DW'(1);
      strobe_nxt = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd    <= 1'b1;
      pause  <= 1'b1;
      rst_p  <= 1'b0;
      strobe <= 1'b0;
      div    <= DW'(DIV_DEFAULT);
      cnt    <= '0;
    end else begin
      fwd    <= fwd_nxt;
      pause  <= pause_nxt;
      rst_p  <= rst_p_nxt;
      strobe <= strobe_nxt;
      div    <= div_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign kybrd_forward  = fwd;
  assign kybrd_pause    = pause;
  assign kybrd_reset    = rst_p;
  assign startsamplenow = strobe;
  assign divisor        = div;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Directed bench for kbd_playback_ctrl.
module tb_kbd_playback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  key_ascii;
  logic        key_valid;
  logic        kybrd_forward, kybrd_pause, kybrd_reset, startsamplenow;
  logic [15:0] divisor;

  int errs   = 0;
  int checks = 0;

  kbd_playback_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_ascii      (key_ascii),
    .key_valid      (key_valid),
    .kybrd_forward  (kybrd_forward),
    .kybrd_pause    (kybrd_pause),
    .kybrd_reset    (kybrd_reset),
    .startsamplenow (startsamplenow),
    .divisor        (divisor)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key is presented for exactly one edge; returns just after that edge
  task automatic press(input logic [7:0] k);
    key_ascii = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_ascii = 8'h00;
  endtask

  // Advance until a strobe is seen or the limit expires
  task automatic wait_strobe(input int limit, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= limit && !ok; i++) begin
      tick();
      n = i;
      if (startsamplenow === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int nstb;
    rst_n = 1'b0; key_valid = 1'b0; key_ascii = 8'h00;
    repeat (3) tick();
    checks++; if (kybrd_forward !== 1'b1) begin errs++; $display("FAIL reset_fwd: got %b want 1", kybrd_forward); end
    checks++; if (kybrd_pause !== 1'b1) begin errs++; $display("FAIL reset_pause: got %b want 1", kybrd_pause); end
    checks++; if (kybrd_reset !== 1'b0) begin errs++; $display("FAIL reset_rst: got %b want 0", kybrd_reset); end
    checks++; if (startsamplenow !== 1'b0) begin errs++; $display("FAIL reset_strobe: got %b want 0", startsamplenow); end
    checks++; if (divisor !== 16'd2272) begin errs++; $display("FAIL reset_div: got %0d want 2272", divisor); end
    rst_n = 1'b1;
    nstb = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (startsamplenow === 1'b1) nstb++;
    end
    checks++; if (nstb != 0) begin errs++; $display("FAIL idle_strobes: got %0d want 0", nstb); end
    checks++; if (kybrd_pause !== 1'b1) begin errs++; $display("FAIL idle_pause: got %b want 1", kybrd_pause); end
    checks++; if (kybrd_forward !== 1'b1) begin errs++; $display("FAIL idle_fwd: got %b want 1", kybrd_forward); end
    checks++; if (divisor !== 16'd2272) begin errs++; $display("FAIL idle_div: got %0d want 2272", divisor); end
  endtask

  task automatic test_play();
    int seen[$];
    press(8'h65);
    checks++; if (kybrd_pause !== 1'b0) begin errs++; $display("FAIL play_pause: got %b want 0", kybrd_pause); end
    for (int i = 1; i <= 7000; i++) begin
      tick();
      if (startsamplenow === 1'b1) seen.push_back(i);
    end
    checks++;
    if (seen.size() != 3) begin
      errs++; $display("FAIL play_count: got %0d strobes want 3", seen.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (seen[k] != 2272 * (k + 1)) begin
          errs++; $display("FAIL play_strobe%0d: got cycle %0d want %0d", k, seen[k], 2272 * (k + 1));
        end
      end
    end
  endtask

  task automatic test_speed();
    int exp_div;
    int n;
    bit ok;
    exp_div = 2272;
    for (int i = 0; i < 40; i++) begin
      press(8'h2B);
      exp_div = (exp_div - 64 < 256) ? 256 : exp_div - 64;
      checks++; if (divisor !== 16'(exp_div)) begin errs++; $display("FAIL speed_up%0d: got %0d want %0d", i, divisor, exp_div); end
    end
    wait_strobe(10000, n, ok);
    checks++; if (!ok) begin errs++; $display("FAIL speed_sync: got no strobe want strobe"); end
    wait_strobe(10000, n, ok);
    checks++; if (!ok || n != 256) begin errs++; $display("FAIL speed_period: got %0d (ok=%0d) want 256", n, ok); end
    for (int i = 0; i < 200; i++) begin
      press(8'h2D);
      exp_div = (exp_div + 64 > 8192) ? 8192 : exp_div + 64;
      checks++; if (divisor !== 16'(exp_div)) begin errs++; $display("FAIL speed_dn%0d: got %0d want %0d", i, divisor, exp_div); end
    end
    press(8'h30);
    checks++; if (divisor !== 16'd2272) begin errs++; $display("FAIL speed_zero: got %0d want 2272", divisor); end
  endtask

  task automatic test_restart();
    int n;
    bit ok;
    wait_strobe(10000, n, ok);
    checks++; if (!ok) begin errs++; $display("FAIL rst_sync: got no strobe want strobe"); end
    repeat (999) tick();
    press(8'h52);
    checks++; if (kybrd_reset !== 1'b1) begin errs++; $display("FAIL rst_pulse: got %b want 1", kybrd_reset); end
    checks++; if (startsamplenow !== 1'b0) begin errs++; $display("FAIL rst_nostrobe: got %b want 0", startsamplenow); end
    checks++; if (kybrd_pause !== 1'b0) begin errs++; $display("FAIL rst_pause: got %b want 0", kybrd_pause); end
    tick();
    checks++; if (kybrd_reset !== 1'b0) begin errs++; $display("FAIL rst_width: got %b want 0", kybrd_reset); end
    wait_strobe(3000, n, ok);
    checks++; if (!ok || n != 2271) begin errs++; $display("FAIL rst_next: got %0d (ok=%0d) want 2271", n, ok); end
    // Restart on the very edge a strobe would fire, then a second restart
    repeat (2271) tick();
    press(8'h72);
    checks++; if (startsamplenow !== 1'b0) begin errs++; $display("FAIL rst_prio: got %b want 0", startsamplenow); end
    checks++; if (kybrd_reset !== 1'b1) begin errs++; $display("FAIL rst_prio_pulse: got %b want 1", kybrd_reset); end
    press(8'h52);
    checks++; if (kybrd_reset !== 1'b1) begin errs++; $display("FAIL rst_b2b: got %b want 1", kybrd_reset); end
    wait_strobe(3000, n, ok);
    checks++; if (!ok || n != 2272) begin errs++; $display("FAIL rst_b2b_next: got %0d (ok=%0d) want 2272", n, ok); end
  endtask

  task automatic test_direction();
    press(8'h42);
    checks++; if (kybrd_forward !== 1'b0) begin errs++; $display("FAIL dir_b: got %b want 0", kybrd_forward); end
    press(8'h41);
    press(8'h20);
    key_ascii = 8'h52; key_valid = 1'b0;
    tick();
    checks++; if (kybrd_reset !== 1'b0) begin errs++; $display("FAIL dir_invalid_rst: got %b want 0", kybrd_reset); end
    key_ascii = 8'h00;
    checks++; if (kybrd_forward !== 1'b0) begin errs++; $display("FAIL dir_hold: got %b want 0", kybrd_forward); end
    press(8'h66);
    checks++; if (kybrd_forward !== 1'b1) begin errs++; $display("FAIL dir_f: got %b want 1", kybrd_forward); end
    checks++; if (kybrd_pause !== 1'b0) begin errs++; $display("FAIL dir_pause: got %b want 0", kybrd_pause); end
    checks++; if (divisor !== 16'd2272) begin errs++; $display("FAIL dir_div: got %0d want 2272", divisor); end
  endtask

  task automatic test_pause_edge();
    int n;
    bit ok;
    wait_strobe(10000, n, ok);
    checks++; if (!ok) begin errs++; $display("FAIL pedge_sync: got no strobe want strobe"); end
    repeat (2271) tick();
    press(8'h44);
    checks++; if (startsamplenow !== 1'b1) begin errs++; $display("FAIL pedge_last: got %b want 1", startsamplenow); end
    checks++; if (kybrd_pause !== 1'b1) begin errs++; $display("FAIL pedge_pause: got %b want 1", kybrd_pause); end
    wait_strobe(5000, n, ok);
    checks++; if (ok) begin errs++; $display("FAIL pedge_quiet: got strobe at %0d want none", n); end
    press(8'h45);
    checks++; if (kybrd_pause !== 1'b0) begin errs++; $display("FAIL pedge_resume: got %b want 0", kybrd_pause); end
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    press(8'h62);
    press(8'h2D);
    checks++; if (divisor !== 16'd2336) begin errs++; $display("FAIL ares_pre_div: got %0d want 2336", divisor); end
    repeat (500) tick();
    press(8'h52);
    key_ascii = 8'h44; key_valid = 1'b1; rst_n = 1'b0;
    #1;
    checks++; if (kybrd_forward !== 1'b1) begin errs++; $display("FAIL ares_fwd: got %b want 1", kybrd_forward); end
    checks++; if (kybrd_pause !== 1'b1) begin errs++; $display("FAIL ares_pause: got %b want 1", kybrd_pause); end
    checks++; if (kybrd_reset !== 1'b0) begin errs++; $display("FAIL ares_rst: got %b want 0", kybrd_reset); end
    checks++; if (divisor !== 16'd2272) begin errs++; $display("FAIL ares_div: got %0d want 2272", divisor); end
    repeat (3) tick();
    key_valid = 1'b0; key_ascii = 8'h00;
    checks++; if (startsamplenow !== 1'b0) begin errs++; $display("FAIL ares_strobe: got %b want 0", startsamplenow); end
    rst_n = 1'b1;
    wait_strobe(5000, n, ok);
    checks++; if (ok) begin errs++; $display("FAIL ares_quiet: got strobe at %0d want none", n); end
    checks++; if (kybrd_pause !== 1'b1) begin errs++; $display("FAIL ares_held: got %b want 1", kybrd_pause); end
    press(8'h45);
    wait_strobe(3000, n, ok);
    checks++; if (!ok || n != 2272) begin errs++; $display("FAIL ares_first: got %0d (ok=%0d) want 2272", n, ok); end
  endtask

  initial begin
    test_reset();
    test_play();
    test_speed();
    test_restart();
    test_direction();
    test_pause_edge();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
